vlsu_ldst: RTL and testbench
============================

Name: vlsu_ldst

Overview:
Parametrised load/store vector unit. Accepts one VLSU instruction at a time from vinsn_launcher.
- Stores: gathers operands from per-lane input FIFOs in lane round-robin order and emits them as a word stream with byte strobes.
- Loads: takes a word stream from memory and distributes it round-robin into per-lane output FIFOs feeding the lane writeback path.
- Reports completion to the committer through a held done/gnt handshake.

Parameters:
NrLanes, NrLane, number of vector lanes; any value >= 1, including non-power-of-two.
WordB, VRFWordWidthB, bytes per VRF word.
InOpBufDepth, 4, depth of each per-lane store operand FIFO.
OutOpBufDepth, 2, depth of each per-lane load result FIFO.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
vfu_req_valid_i  in  1  launcher request valid
vfu_req_ready_o  out  1  unit can accept a request
target_vfu_i  in  vfu_e  request target; accepted only when == VLSU
vfu_req_i  in  vfu_req_t  request: insn_id, vlB, vlsu_op
store_op_valid_i  in  NrLanes  per-lane store operand valid
store_op_ready_o  out  NrLanes  per-lane FIFO not full
store_op_i  in  NrLanes x vrf_data_t  per-lane store operands
store_op_valid_o  out  1  store word valid toward memory
store_op_gnt_i  in  1  memory accepts store word
store_op_o  out  vrf_data_t  store word
store_strb_o  out  WordB  byte enables of store word
load_data_valid_i  in  1  memory load word valid
load_data_ready_o  out  1  load word accepted this cycle
load_data_i  in  vrf_data_t  load word
load_op_valid_o  out  NrLanes  per-lane load result valid
load_op_ready_i  in  NrLanes  lane accepts load result
load_op_o  out  NrLanes x vrf_data_t  per-lane load results
done_gnt_i  in  1  committer accepts done
done_o  out  1  instruction complete
done_insn_id_o  out  insn_id_t  id of completed instruction

Behaviour:
- Reset: state IDLE, lane_q=0, all FIFOs empty. Every valid/done/ready output is 0 except vfu_req_ready_o=1 and store_op_ready_o=all 1. Data outputs are don't-care. Reset mid-operation discards all buffered data and the current instruction.
- States: IDLE, STORE, LOAD, WAIT.
- IDLE: vfu_req_ready_o=1. On vfu_req_valid_i && target_vfu_i==VLSU, latch the request and go to STORE or LOAD per vlsu_op. If vlB==0, go directly to WAIT with no transfers.
- Lane pointer lane_q: increments on each transferred word and wraps from NrLanes-1 to 0 by compare, not by overflow. It is reset to 0 at instruction end.
- STORE:
  - store_op_valid_o = FIFO[lane_q] non-empty; store_op_o = FIFO[lane_q] head.
  - On store_op_gnt_i && store_op_valid_o: pop FIFO[lane_q], decrement rem_q by WordB, advance lane_q.
  - store_strb_o is all ones, except on the final word when vlB mod WordB != 0; then only the low (vlB mod WordB) bits are set.
  - store_op_gnt_i while store_op_valid_o=0 is ignored.
- LOAD:
  - load_data_ready_o = out FIFO[lane_q] not full.
  - On load_data_valid_i && load_data_ready_o: push into FIFO[lane_q], decrement rem_q, advance lane_q.
  - Each load_op_valid_o[i] = out FIFO[i] non-empty; each lane pops independently on load_op_ready_i[i].
  - Completion condition: all words pushed AND all out FIFOs empty, i.e. the data has been delivered to the lanes.
- Completion cycle:
  - done_o=1, done_insn_id_o = latched insn_id.
  - If done_gnt_i=0, go to WAIT.
  - If done_gnt_i=1 and a new VLSU request is valid the same cycle, accept it (vfu_req_ready_o=1) and enter its state directly with zero bubble.
  - Otherwise return to IDLE.
- WAIT: done_o held at 1 with stable id until done_gnt_i. Next-request handling on done_gnt_i is identical to the completion cycle.
- rem_q: width $bits(vlen_t). Last word is detected when rem_q <= WordB, which avoids unsigned underflow.
- Store input FIFOs accept pushes in every state, so operands may arrive ahead of the instruction.
- Simultaneous push and pop on a full FIFO is not permitted. ready is a pure function of full, so a push is refused while full.

Decomposition:
- core_pkg additions: vlsu_op_e {VLSU_LOAD, VLSU_STORE}, field vfu_req_t.vlsu_op, constant VRFWordWidthB (already present).
- Local: state enum.
- Per-lane buffers instantiate fifo_v3 (2*NrLanes instances).
- One natural sub-module: vlsu_lane_rr (lane pointer plus rem counter plus last/strobe generation), shared by the load and store paths.

Test Plan:
All scenarios use NrLanes=4, WordB=8.
1. Store, vlB=32: preload lanes 0..3 with A,B,C,D; hold gnt=1 -> store_op_o A,B,C,D on four consecutive cycles, strb 0xFF each; done_o on the D cycle; with done_gnt_i=1, IDLE next.
2. Store, vlB=20: preload lanes 0..2 -> three words, strobes 0xFF, 0xFF, 0x0F; lane 3 FIFO untouched.
3. Load, vlB=48, load_op_ready_i=0 for lane 1:
   - Words 0..5 are accepted; words 1 and 5 land in lane 1's FIFO (depth 2).
   - Lanes 0, 2, 3 drain as their words arrive; done_o stays 0.
   - Raise load_op_ready_i[1] -> lane 1 FIFO drains in 2 cycles, then done_o=1.
4. Load backpressure: lane 0 FIFO full, load_data_valid_i=1 with lane_q=0 -> load_data_ready_o=0 until a lane 0 pop.
5. Back-to-back: store completes with done_gnt_i=1 and a valid load request the same cycle -> request accepted, next cycle in LOAD. With done_gnt_i=0 -> WAIT, done_o held, id unchanged for 3 cycles.
6. Reset mid-LOAD after 2 words -> all outputs at reset values next edge; vlB=0 request afterwards -> done_o the next cycle with no transfers.

Source files
------------

// File: rtl/vlsu_ldst_pkg.sv
// Shared types and constants for the vector load/store unit.
package vlsu_ldst_pkg;

  localparam int unsigned VRFWordWidthB = 8;
  localparam int unsigned VLenW         = 16;
  localparam int unsigned InsnIdW       = 3;

  typedef logic [8*VRFWordWidthB-1:0] vrf_data_t;
  typedef logic [VLenW-1:0]           vlen_t;
  typedef logic [InsnIdW-1:0]         insn_id_t;

  typedef enum logic [2:0] {ALU, MFPU, SLDU, MASKU, VLSU} vfu_e;

  typedef enum logic {VLSU_LOAD, VLSU_STORE} vlsu_op_e;

  typedef struct packed {
    insn_id_t insn_id;
    vlen_t    vlB;
    vlsu_op_e vlsu_op;
  } vfu_req_t;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vlsu_ldst_if.sv
// Handshake and data bus between the load/store unit and its neighbours
// (launcher, lanes, memory, committer).
interface vlsu_ldst_if #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned WordB   = vlsu_ldst_pkg::VRFWordWidthB
);
  import vlsu_ldst_pkg::*;

  logic                       vfu_req_valid_i;
  logic                       vfu_req_ready_o;
  vfu_e                       target_vfu_i;
  vfu_req_t                   vfu_req_i;
  logic [NrLanes-1:0]         store_op_valid_i;
  logic [NrLanes-1:0]         store_op_ready_o;
  vrf_data_t [NrLanes-1:0]    store_op_i;
  logic                       store_op_valid_o;
  logic                       store_op_gnt_i;
  vrf_data_t                  store_op_o;
  logic [WordB-1:0]           store_strb_o;
  logic                       load_data_valid_i;
  logic                       load_data_ready_o;
  vrf_data_t                  load_data_i;
  logic [NrLanes-1:0]         load_op_valid_o;
  logic [NrLanes-1:0]         load_op_ready_i;
  vrf_data_t [NrLanes-1:0]    load_op_o;
  logic                       done_gnt_i;
  logic                       done_o;
  insn_id_t                   done_insn_id_o;

  modport master (
    output vfu_req_valid_i, target_vfu_i, vfu_req_i, store_op_valid_i, store_op_i,
           store_op_gnt_i, load_data_valid_i, load_data_i, load_op_ready_i, done_gnt_i,
    input  vfu_req_ready_o, store_op_ready_o, store_op_valid_o, store_op_o, store_strb_o,
           load_data_ready_o, load_op_valid_o, load_op_o, done_o, done_insn_id_o
  );

  modport slave (
    input  vfu_req_valid_i, target_vfu_i, vfu_req_i, store_op_valid_i, store_op_i,
           store_op_gnt_i, load_data_valid_i, load_data_i, load_op_ready_i, done_gnt_i,
    output vfu_req_ready_o, store_op_ready_o, store_op_valid_o, store_op_o, store_strb_o,
           load_data_ready_o, load_op_valid_o, load_op_o, done_o, done_insn_id_o
  );

endinterface

// File: rtl/fifo_v3.sv
// Small synchronous FIFO; push is refused while full, pop while empty.
module fifo_v3 #(
  parameter int unsigned DEPTH = 2,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output dtype data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  dtype             mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap by compare so any depth works.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == AddrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == AddrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array carries data only, so it is not reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vlsu_ldst_lane_rr.sv
// Lane round-robin pointer and remaining-byte counter shared by the load and
// store paths; also derives the last-word flag and the byte strobe.
module vlsu_ldst_lane_rr
  import vlsu_ldst_pkg::*;
#(
  parameter  int unsigned NrLanes = 4,
  parameter  int unsigned WordB   = VRFWordWidthB,
  localparam int unsigned LaneW   = idx_width(NrLanes)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  vlen_t            vlB_i,
  input  logic             step_i,
  input  logic             clear_i,
  output logic [LaneW-1:0] lane_o,
  output logic             last_o,
  output logic             rem_zero_o,
  output logic [WordB-1:0] strb_o
);

  logic [LaneW-1:0] lane_q, lane_d;
  vlen_t            rem_q, rem_d;

  // Byte b is enabled while it lies below the remaining byte count; this
  // yields all ones except on a partial final word.
  function automatic logic [WordB-1:0] gen_strb(input vlen_t rem);
    logic [WordB-1:0] s;
    for (int b = 0; b < WordB; b++) s[b] = (vlen_t'(b) < rem);
    return s;
  endfunction

  // Compare against WordB instead of subtracting first, so rem never underflows.
  assign last_o     = (rem_q <= vlen_t'(WordB));
  assign rem_zero_o = (rem_q == '0);
  assign strb_o     = gen_strb(rem_q);
  assign lane_o     = lane_q;

  // New instruction wins over end-of-instruction, which wins over a transfer.
  always_comb begin
    lane_d = lane_q;
    rem_d  = rem_q;
    if (start_i) begin
      lane_d = '0;
      rem_d  = vlB_i;
    end else if (clear_i) begin
      lane_d = '0;
      rem_d  = '0;
    end else if (step_i) begin
      lane_d = (lane_q == LaneW'(NrLanes - 1)) ? '0 : lane_q + 1'b1;
      rem_d  = last_o ? '0 : rem_q - vlen_t'(WordB);
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q <= '0;
      rem_q  <= '0;
    end else begin
      lane_q <= lane_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/vlsu_ldst.sv
// Vector load/store unit: gathers per-lane store operands into a memory word
// stream, scatters memory load words into per-lane result FIFOs, and reports
// completion to the committer with a held done/gnt handshake.
module vlsu_ldst
  import vlsu_ldst_pkg::*;
#(
  parameter  int unsigned NrLanes       = 4,
  parameter  int unsigned WordB         = VRFWordWidthB,
  parameter  int unsigned InOpBufDepth  = 4,
  parameter  int unsigned OutOpBufDepth = 2,
  localparam int unsigned LaneW         = idx_width(NrLanes)
) (
  input logic         clk_i,
  input logic         rst_ni,
  vlsu_ldst_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, STORE, LOAD, WAIT} state_e;

  state_e             state_q, state_d;
  insn_id_t           insn_id_q;
  logic [LaneW-1:0]   lane_q;
  logic               last_word, rem_zero;
  logic               st_fire, ld_fire, complete, req_accept;
  logic [NrLanes-1:0] in_full, in_empty, out_full, out_empty;
  vrf_data_t          in_head  [NrLanes];
  vrf_data_t          out_head [NrLanes];

  vlsu_ldst_lane_rr #(
    .NrLanes (NrLanes),
    .WordB   (WordB)
  ) i_lane_rr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (req_accept),
    .vlB_i      (bus.vfu_req_i.vlB),
    .step_i     (st_fire || ld_fire),
    .clear_i    (complete),
    .lane_o     (lane_q),
    .last_o     (last_word),
    .rem_zero_o (rem_zero),
    .strb_o     (bus.store_strb_o)
  );

  for (genvar l = 0; l < NrLanes; l++) begin : g_lane
    // Store operands may arrive ahead of the instruction, so pushes are never gated by state.
    fifo_v3 #(
      .DEPTH (InOpBufDepth),
      .dtype (vrf_data_t)
    ) i_in_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (bus.store_op_valid_i[l]),
      .data_i  (bus.store_op_i[l]),
      .pop_i   (st_fire && (lane_q == LaneW'(l))),
      .data_o  (in_head[l]),
      .full_o  (in_full[l]),
      .empty_o (in_empty[l])
    );

    fifo_v3 #(
      .DEPTH (OutOpBufDepth),
      .dtype (vrf_data_t)
    ) i_out_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (ld_fire && (lane_q == LaneW'(l))),
      .data_i  (bus.load_data_i),
      .pop_i   (bus.load_op_ready_i[l]),
      .data_o  (out_head[l]),
      .full_o  (out_full[l]),
      .empty_o (out_empty[l])
    );
  end

  assign bus.store_op_ready_o = ~in_full;
  assign bus.load_op_valid_o  = ~out_empty;
  assign bus.store_op_o       = in_head[lane_q];
  assign bus.done_insn_id_o   = insn_id_q;

  // Pack the per-lane FIFO heads onto the lane writeback bus.
  always_comb begin
    for (int l = 0; l < NrLanes; l++) bus.load_op_o[l] = out_head[l];
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state; a request accepted on the completion cycle enters its state with no bubble.
  always_comb begin
    state_d = state_q;
    if (req_accept) begin
      if (bus.vfu_req_i.vlB == '0)                 state_d = WAIT;
      else if (bus.vfu_req_i.vlsu_op == VLSU_STORE) state_d = STORE;
      else                                          state_d = LOAD;
    end else if (complete) begin
      state_d = bus.done_gnt_i ? IDLE : WAIT;
    end
  end

  // Outputs and transfer strobes; a load completes only once every lane has drained.
  always_comb begin
    bus.vfu_req_ready_o   = 1'b0;
    bus.store_op_valid_o  = 1'b0;
    bus.load_data_ready_o = 1'b0;
    st_fire               = 1'b0;
    ld_fire               = 1'b0;
    complete              = 1'b0;
    case (state_q)
      IDLE: bus.vfu_req_ready_o = 1'b1;
      STORE: begin
        bus.store_op_valid_o = !in_empty[lane_q];
        st_fire              = bus.store_op_valid_o && bus.store_op_gnt_i;
        complete             = st_fire && last_word;
      end
      LOAD: begin
        bus.load_data_ready_o = !rem_zero && !out_full[lane_q];
        ld_fire               = bus.load_data_ready_o && bus.load_data_valid_i;
        complete              = rem_zero && (&out_empty);
      end
      WAIT: complete = 1'b1;
      default: ;
    endcase
    bus.done_o = complete;
    if (complete && bus.done_gnt_i) bus.vfu_req_ready_o = 1'b1;
    req_accept = bus.vfu_req_ready_o && bus.vfu_req_valid_i && (bus.target_vfu_i == VLSU);
  end

  // Instruction id held for the done report.
  always_ff @(posedge clk_i) begin
    if (req_accept) insn_id_q <= bus.vfu_req_i.insn_id;
  end

endmodule

// File: tb/tb_vlsu_ldst.sv
// Directed bench for vlsu_ldst with NrLanes=4, WordB=8.
module tb_vlsu_ldst;
  import vlsu_ldst_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vlsu_ldst_if #(.NrLanes(4), .WordB(8)) bus ();

  vlsu_ldst #(
    .NrLanes       (4),
    .WordB         (8),
    .InOpBufDepth  (4),
    .OutOpBufDepth (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  function automatic vrf_data_t W(input int k);
    return 64'hC0DE_0000_0000_0000 | vrf_data_t'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(negedge clk);
  endtask

  task automatic req(input insn_id_t id, input vlen_t vlb, input vlsu_op_e op);
    bus.vfu_req_valid_i = 1'b1;
    bus.target_vfu_i    = VLSU;
    bus.vfu_req_i       = '{insn_id: id, vlB: vlb, vlsu_op: op};
  endtask

  initial begin
    bus.vfu_req_valid_i   = 1'b0;
    bus.target_vfu_i      = ALU;
    bus.vfu_req_i         = '0;
    bus.store_op_valid_i  = '0;
    bus.store_op_i        = '0;
    bus.store_op_gnt_i    = 1'b0;
    bus.load_data_valid_i = 1'b0;
    bus.load_data_i       = '0;
    bus.load_op_ready_i   = '0;
    bus.done_gnt_i        = 1'b0;

    // Reset values
    go(); #1;
    chk("rst_req_ready", bus.vfu_req_ready_o, 1);
    chk("rst_st_ready", bus.store_op_ready_o, 4'hF);
    chk("rst_st_valid", bus.store_op_valid_o, 0);
    chk("rst_ld_ready", bus.load_data_ready_o, 0);
    chk("rst_ld_valid", bus.load_op_valid_o, 0);
    chk("rst_done", bus.done_o, 0);
    go(); rst_n = 1'b1;

    // Request aimed at another unit is ignored
    bus.vfu_req_valid_i = 1'b1;
    bus.target_vfu_i    = ALU;
    bus.vfu_req_i       = '{insn_id: 3'd7, vlB: 16'd32, vlsu_op: VLSU_STORE};
    go(); bus.vfu_req_valid_i = 1'b0; #1;
    chk("foreign_req_ready", bus.vfu_req_ready_o, 1);
    chk("foreign_done", bus.done_o, 0);

    // 1: store vlB=32, four full words
    bus.store_op_valid_i = 4'hF;
    bus.store_op_i = {W(13), W(12), W(11), W(10)};
    go(); bus.store_op_valid_i = '0;
    req(3'd1, 16'd32, VLSU_STORE);
    bus.store_op_gnt_i = 1'b1;
    bus.done_gnt_i     = 1'b1;
    #1;
    chk("s1_idle_ready", bus.vfu_req_ready_o, 1);
    chk("s1_idle_valid", bus.store_op_valid_o, 0);
    go(); bus.vfu_req_valid_i = 1'b0; #1;
    chk("s1_w0_valid", bus.store_op_valid_o, 1);
    chk("s1_w0_data", bus.store_op_o, W(10));
    chk("s1_w0_strb", bus.store_strb_o, 8'hFF);
    chk("s1_w0_done", bus.done_o, 0);
    go(); #1;
    chk("s1_w1_data", bus.store_op_o, W(11));
    go(); #1;
    chk("s1_w2_data", bus.store_op_o, W(12));
    go(); #1;
    chk("s1_w3_data", bus.store_op_o, W(13));
    chk("s1_w3_strb", bus.store_strb_o, 8'hFF);
    chk("s1_w3_done", bus.done_o, 1);
    chk("s1_w3_id", bus.done_insn_id_o, 1);
    go(); #1;
    chk("s1_idle_after", bus.vfu_req_ready_o, 1);
    chk("s1_done_after", bus.done_o, 0);
    chk("s1_valid_after", bus.store_op_valid_o, 0);

    // 2: store vlB=20, partial last word
    bus.store_op_valid_i = 4'b0111;
    bus.store_op_i = {64'd0, W(22), W(21), W(20)};
    go(); bus.store_op_valid_i = '0;
    req(3'd2, 16'd20, VLSU_STORE);
    go(); bus.vfu_req_valid_i = 1'b0; #1;
    chk("s2_w0_data", bus.store_op_o, W(20));
    chk("s2_w0_strb", bus.store_strb_o, 8'hFF);
    go(); #1;
    chk("s2_w1_data", bus.store_op_o, W(21));
    chk("s2_w1_strb", bus.store_strb_o, 8'hFF);
    chk("s2_w1_done", bus.done_o, 0);
    go(); #1;
    chk("s2_w2_data", bus.store_op_o, W(22));
    chk("s2_w2_strb", bus.store_strb_o, 8'h0F);
    chk("s2_w2_done", bus.done_o, 1);
    chk("s2_w2_id", bus.done_insn_id_o, 2);
    go(); #1;
    chk("s2_done_after", bus.done_o, 0);
    chk("s2_st_ready", bus.store_op_ready_o, 4'hF);

    // 3: load vlB=48, lane 1 stalled
    bus.store_op_gnt_i  = 1'b0;
    bus.load_op_ready_i = 4'b1101;
    req(3'd3, 16'd48, VLSU_LOAD);
    go(); bus.vfu_req_valid_i = 1'b0;
    bus.load_data_valid_i = 1'b1; bus.load_data_i = W(30); #1;
    chk("l3_k0_ready", bus.load_data_ready_o, 1);
    go(); bus.load_data_i = W(31); #1;
    chk("l3_k1_lov", bus.load_op_valid_o, 4'b0001);
    chk("l3_k1_op0", bus.load_op_o[0], W(30));
    chk("l3_k1_ready", bus.load_data_ready_o, 1);
    go(); bus.load_data_i = W(32); #1;
    chk("l3_k2_lov", bus.load_op_valid_o, 4'b0010);
    go(); bus.load_data_i = W(33); #1;
    chk("l3_k3_lov", bus.load_op_valid_o, 4'b0110);
    go(); bus.load_data_i = W(34); #1;
    chk("l3_k4_lov", bus.load_op_valid_o, 4'b1010);
    go(); bus.load_data_i = W(35); #1;
    chk("l3_k5_lov", bus.load_op_valid_o, 4'b0011);
    chk("l3_k5_ready", bus.load_data_ready_o, 1);
    go(); bus.load_data_valid_i = 1'b0; #1;
    chk("l3_k6_lov", bus.load_op_valid_o, 4'b0010);
    chk("l3_k6_op1", bus.load_op_o[1], W(31));
    chk("l3_k6_ready", bus.load_data_ready_o, 0);
    chk("l3_k6_done", bus.done_o, 0);
    go(); #1;
    chk("l3_k7_done", bus.done_o, 0);
    bus.load_op_ready_i = 4'hF; #1;
    chk("l3_drain0_op1", bus.load_op_o[1], W(31));
    go(); #1;
    chk("l3_drain1_op1", bus.load_op_o[1], W(35));
    chk("l3_drain1_done", bus.done_o, 0);
    go(); #1;
    chk("l3_end_lov", bus.load_op_valid_o, 0);
    chk("l3_end_done", bus.done_o, 1);
    chk("l3_end_id", bus.done_insn_id_o, 3);
    go(); #1;
    chk("l3_idle_done", bus.done_o, 0);

    // 4: load backpressure on a full lane-0 FIFO
    bus.load_op_ready_i = 4'h0;
    req(3'd4, 16'd80, VLSU_LOAD);
    go(); bus.vfu_req_valid_i = 1'b0; bus.load_data_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.load_data_i = W(40 + k); #1;
      chk("l4_fill_ready", bus.load_data_ready_o, 1);
      go();
    end
    #1;
    chk("l4_bp_ready", bus.load_data_ready_o, 0);
    chk("l4_bp_lov", bus.load_op_valid_o, 4'hF);
    go(); #1;
    chk("l4_bp_hold", bus.load_data_ready_o, 0);
    bus.load_op_ready_i = 4'hF; bus.load_data_i = W(48); #1;
    chk("l4_pop_ready", bus.load_data_ready_o, 0);
    chk("l4_pop_op0", bus.load_op_o[0], W(40));
    go(); #1;
    chk("l4_t1_ready", bus.load_data_ready_o, 1);
    chk("l4_t1_op0", bus.load_op_o[0], W(44));
    go(); bus.load_data_i = W(49); #1;
    chk("l4_t2_ready", bus.load_data_ready_o, 1);
    chk("l4_t2_op0", bus.load_op_o[0], W(48));
    go(); bus.load_data_valid_i = 1'b0; #1;
    chk("l4_t3_lov", bus.load_op_valid_o, 4'b0010);
    chk("l4_t3_op1", bus.load_op_o[1], W(49));
    chk("l4_t3_done", bus.done_o, 0);
    go(); #1;
    chk("l4_t4_done", bus.done_o, 1);
    chk("l4_t4_id", bus.done_insn_id_o, 4);
    go();

    // 5: back-to-back store -> load, then held done in WAIT
    bus.store_op_gnt_i   = 1'b1;
    bus.store_op_valid_i = 4'b0001;
    bus.store_op_i       = {64'd0, 64'd0, 64'd0, W(50)};
    go(); bus.store_op_valid_i = '0;
    req(3'd5, 16'd8, VLSU_STORE);
    go(); req(3'd6, 16'd16, VLSU_LOAD); #1;
    chk("b5_st_data", bus.store_op_o, W(50));
    chk("b5_st_strb", bus.store_strb_o, 8'hFF);
    chk("b5_st_done", bus.done_o, 1);
    chk("b5_st_id", bus.done_insn_id_o, 5);
    chk("b5_st_req_ready", bus.vfu_req_ready_o, 1);
    go(); bus.vfu_req_valid_i = 1'b0;
    bus.load_data_valid_i = 1'b1; bus.load_data_i = W(60); #1;
    chk("b5_ld_ready", bus.load_data_ready_o, 1);
    chk("b5_ld_req_ready", bus.vfu_req_ready_o, 0);
    chk("b5_ld_done", bus.done_o, 0);
    go(); bus.load_data_i = W(61); #1;
    chk("b5_ld_lov", bus.load_op_valid_o, 4'b0001);
    go(); bus.load_data_valid_i = 1'b0; bus.done_gnt_i = 1'b0; #1;
    chk("b5_ld_op1", bus.load_op_o[1], W(61));
    chk("b5_ld_done0", bus.done_o, 0);
    go(); req(3'd7, 16'd8, VLSU_STORE); #1;
    chk("b5_cmp_done", bus.done_o, 1);
    chk("b5_cmp_id", bus.done_insn_id_o, 6);
    chk("b5_cmp_req_ready", bus.vfu_req_ready_o, 0);
    go();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b5_wait_done", bus.done_o, 1);
      chk("b5_wait_id", bus.done_insn_id_o, 6);
      chk("b5_wait_req_ready", bus.vfu_req_ready_o, 0);
      go();
    end
    bus.vfu_req_valid_i = 1'b0; bus.done_gnt_i = 1'b1; #1;
    chk("b5_gnt_done", bus.done_o, 1);
    chk("b5_gnt_req_ready", bus.vfu_req_ready_o, 1);
    go(); #1;
    chk("b5_idle_done", bus.done_o, 0);

    // 6: reset mid-load, then a zero-length request
    bus.load_op_ready_i = 4'h0;
    req(3'd1, 16'd32, VLSU_LOAD);
    go(); bus.vfu_req_valid_i = 1'b0;
    bus.load_data_valid_i = 1'b1; bus.load_data_i = W(70);
    go(); bus.load_data_i = W(71);
    go(); bus.load_data_valid_i = 1'b0; #1;
    chk("r6_pre_lov", bus.load_op_valid_o, 4'b0011);
    rst_n = 1'b0; #1;
    chk("r6_rst_lov", bus.load_op_valid_o, 0);
    chk("r6_rst_ld_ready", bus.load_data_ready_o, 0);
    chk("r6_rst_req_ready", bus.vfu_req_ready_o, 1);
    chk("r6_rst_st_ready", bus.store_op_ready_o, 4'hF);
    chk("r6_rst_done", bus.done_o, 0);
    go(); rst_n = 1'b1;
    req(3'd2, 16'd0, VLSU_LOAD);
    go(); bus.vfu_req_valid_i = 1'b0; #1;
    chk("r6_z_done", bus.done_o, 1);
    chk("r6_z_id", bus.done_insn_id_o, 2);
    chk("r6_z_ld_ready", bus.load_data_ready_o, 0);
    chk("r6_z_lov", bus.load_op_valid_o, 0);
    go(); #1;
    chk("r6_z_after", bus.done_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
